// File: rtl/sobel_scan_gen.sv
// sobel_scan_gen: walks the interior pixels of a row-major frame and
// issues the nine 3x3 neighbour reads with their Sobel Gx/Gy coefficients.
module sobel_scan_gen #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 16
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                Enable,
  output logic [ADDR_W-1:0]   RdAddr,
  output logic                RdValid,
  output logic [3:0]          Tap,
  output logic signed [2:0]   Kx,
  output logic signed [2:0]   Ky,
  output logic                WinLast,
  output logic [ADDR_W-1:0]   WrAddr,
  output logic                isEnd
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 2);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 2);

  // centre of window (1,1) and distance from a centre back to its tap 0
  localparam logic [ADDR_W-1:0] CTR0     = ADDR_W'(IMG_W + 1);
  localparam logic [ADDR_W-1:0] TAP_BACK = ADDR_W'(IMG_W + 1);
  // from tap column 2 of one window row to tap column 0 of the next
  localparam logic [ADDR_W-1:0] ROW_JMP  = ADDR_W'(IMG_W - 2);
  // row wrap: c jumps from W-2 back to 1 on the next row
  localparam logic [ADDR_W-1:0] WRAP_JMP = ADDR_W'(3);

  typedef enum logic {SCAN, DONE} state_e;

  state_e state_q, state_d;

  logic [RW-1:0]     r_q, r_d;
  logic [CW-1:0]     c_q, c_d;
  logic [3:0]        t_q, t_d;
  logic [1:0]        tc_q, tc_d;
  logic [ADDR_W-1:0] ctr_q, ctr_d;
  logic [ADDR_W-1:0] ra_q, ra_d;

  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_valid_q, rd_valid_d;
  logic [3:0]        tap_q, tap_d;
  logic [2:0]        kx_q, kx_d;
  logic [2:0]        ky_q, ky_d;
  logic              win_last_q, win_last_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              is_end_q, is_end_d;

  logic issue;
  logic last_tap;

  // an issue happens on every enabled edge while scanning
  always_comb begin
    issue    = Enable && (state_q == SCAN);
    last_tap = (r_q == R_LAST) && (c_q == C_LAST) && (t_q == 4'd8);
  end

  // state register
  always_ff @(posedge CLK) begin
    if (Reset) state_q <= SCAN;
    else       state_q <= state_d;
  end

  // next state: leave SCAN on the final tap, DONE only exits via Reset
  always_comb begin
    state_d = state_q;
    if (issue && last_tap) state_d = DONE;
  end

  // scan counters and incrementally maintained addresses
  always_comb begin
    r_d   = r_q;
    c_d   = c_q;
    t_d   = t_q;
    tc_d  = tc_q;
    ctr_d = ctr_q;
    ra_d  = ra_q;
    if (issue) begin
      if (t_q == 4'd8) begin
        t_d  = 4'd0;
        tc_d = 2'd0;
        if (c_q == C_LAST) begin
          c_d   = CW'(1);
          r_d   = r_q + RW'(1);
          ctr_d = ctr_q + WRAP_JMP;
        end else begin
          c_d   = c_q + CW'(1);
          ctr_d = ctr_q + ADDR_W'(1);
        end
        ra_d = ctr_d - TAP_BACK;
      end else begin
        t_d = t_q + 4'd1;
        if (tc_q == 2'd2) begin
          tc_d = 2'd0;
          ra_d = ra_q + ROW_JMP;
        end else begin
          tc_d = tc_q + 2'd1;
          ra_d = ra_q + ADDR_W'(1);
        end
      end
    end
  end

  // counter registers
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_q   <= RW'(1);
      c_q   <= CW'(1);
      t_q   <= 4'd0;
      tc_q  <= 2'd0;
      ctr_q <= CTR0;
      ra_q  <= '0;
    end else begin
      r_q   <= r_d;
      c_q   <= c_d;
      t_q   <= t_d;
      tc_q  <= tc_d;
      ctr_q <= ctr_d;
      ra_q  <= ra_d;
    end
  end

  // outputs: load current tap on issue, otherwise hold data and drop strobes
  always_comb begin
    rd_addr_d  = rd_addr_q;
    tap_d      = tap_q;
    kx_d       = kx_q;
    ky_d       = ky_q;
    wr_addr_d  = wr_addr_q;
    rd_valid_d = 1'b0;
    win_last_d = 1'b0;
    is_end_d   = is_end_q;
    if (issue) begin
      rd_addr_d  = ra_q;
      tap_d      = t_q;
      wr_addr_d  = ctr_q;
      rd_valid_d = 1'b1;
      win_last_d = (t_q == 4'd8);
      if (last_tap) is_end_d = 1'b1;
      unique case (t_q)
        4'd0:    begin kx_d = 3'b111; ky_d = 3'b111; end
        4'd1:    begin kx_d = 3'b000; ky_d = 3'b110; end
        4'd2:    begin kx_d = 3'b001; ky_d = 3'b111; end
        4'd3:    begin kx_d = 3'b110; ky_d = 3'b000; end
        4'd4:    begin kx_d = 3'b000; ky_d = 3'b000; end
        4'd5:    begin kx_d = 3'b010; ky_d = 3'b000; end
        4'd6:    begin kx_d = 3'b111; ky_d = 3'b001; end
        4'd7:    begin kx_d = 3'b000; ky_d = 3'b010; end
        4'd8:    begin kx_d = 3'b001; ky_d = 3'b001; end
        default: begin kx_d = 3'b000; ky_d = 3'b000; end
      endcase
    end
  end

  // output registers
  always_ff @(posedge CLK) begin
    if (Reset) begin
      rd_addr_q  <= '0;
      rd_valid_q <= 1'b0;
      tap_q      <= 4'd0;
      kx_q       <= 3'd0;
      ky_q       <= 3'd0;
      win_last_q <= 1'b0;
      wr_addr_q  <= '0;
      is_end_q   <= 1'b0;
    end else begin
      rd_addr_q  <= rd_addr_d;
      rd_valid_q <= rd_valid_d;
      tap_q      <= tap_d;
      kx_q       <= kx_d;
      ky_q       <= ky_d;
      win_last_q <= win_last_d;
      wr_addr_q  <= wr_addr_d;
      is_end_q   <= is_end_d;
    end
  end

  assign RdAddr  = rd_addr_q;
  assign RdValid = rd_valid_q;
  assign Tap     = tap_q;
  assign Kx      = kx_q;
  assign Ky      = ky_q;
  assign WinLast = win_last_q;
  assign WrAddr  = wr_addr_q;
  assign isEnd   = is_end_q;

endmodule
